// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and square defaults for the VGA square path
package vga_pkg;

    typedef enum logic [1:0] {
        MV_RIGHT = 2'b00,
        MV_LEFT  = 2'b01,
        MV_UP    = 2'b10,
        MV_DOWN  = 2'b11
    } move_dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_APPLY = 2'b10,
        ST_HOME  = 2'b11
    } sched_state_t;

    localparam int SQ_STEP   = 8;
    localparam int SQ_X_INIT = 150;
    localparam int SQ_Y_INIT = 100;
    localparam int SQ_X_MAX  = 792;
    localparam int SQ_Y_MAX  = 592;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing bus (pixel counters) shared between stages
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;

    modport in  (input  hcount, input  vcount);
    modport out (output hcount, output vcount);
endinterface

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - small synchronous FIFO of 2-bit move commands
module move_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [1:0]               din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [1:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // pointer and occupancy bookkeeping; flush discards everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // storage write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/square_move_sched.sv
// rtl/square_move_sched.sv - frame-synchronous square move scheduler (option: SQUARE_WRAP_EN)
module square_move_sched
    import vga_pkg::*;
#(
    parameter int STEP       = SQ_STEP,
    parameter int FIFO_DEPTH = 4,
    parameter int X_INIT     = SQ_X_INIT,
    parameter int Y_INIT     = SQ_Y_INIT,
    parameter int X_MAX      = SQ_X_MAX,
    parameter int Y_MAX      = SQ_Y_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    vga_if.in                             vga_in,
    input  logic                          mouse_left,
    input  logic                          mouse_right,
    input  logic                          key_valid,
    input  logic [1:0]                    key_dir,
    output logic                          key_ready,
    input  logic                          home,
    output logic [11:0]                   xpos_square,
    output logic [11:0]                   ypos_square,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef SQUARE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    sched_state_t state, state_next;

    logic          mouse_l_q, mouse_r_q;
    logic          rise_l, rise_r, mouse_req;
    move_dir_t     mouse_dir;
    logic          hold_valid;
    move_dir_t     hold_dir;
    logic          last_mouse;

    logic          push, pop, can_push, grant_mouse, hold_load, hold_clear;
    move_dir_t     push_dir;
    logic [1:0]    head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic          frame_start;

    logic [12:0]   x_sum, y_sum;
    logic [11:0]   x_next, y_next;

    assign frame_start = (vga_in.hcount == '0) && (vga_in.vcount == '0);
    assign rise_l      = mouse_left  && !mouse_l_q;
    assign rise_r      = mouse_right && !mouse_r_q;
    // both buttons rising together is ambiguous and is ignored
    assign mouse_req   = rise_l ^ rise_r;
    assign mouse_dir   = rise_r ? MV_RIGHT : MV_LEFT;
    assign pending     = count;

    move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_dir),
        .pop   (pop),
        .flush (home),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // button history for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mouse_l_q <= 1'b0;
            mouse_r_q <= 1'b0;
        end else begin
            mouse_l_q <= mouse_left;
            mouse_r_q <= mouse_right;
        end
    end

    // arbitration: held mouse move first, then round-robin between mouse and keyboard
    always_comb begin
        can_push    = (!full || pop) && (state != ST_HOME) && !home;
        push        = 1'b0;
        push_dir    = MV_RIGHT;
        grant_mouse = 1'b0;
        hold_load   = 1'b0;
        hold_clear  = 1'b0;
        key_ready   = 1'b0;
        if (hold_valid) begin
            if (can_push) begin
                push        = 1'b1;
                push_dir    = hold_dir;
                grant_mouse = 1'b1;
                hold_clear  = 1'b1;
                hold_load   = mouse_req;
            end
        end else if (mouse_req && key_valid && last_mouse) begin
            key_ready = can_push;
            if (can_push) begin
                push      = 1'b1;
                push_dir  = move_dir_t'(key_dir);
                hold_load = 1'b1;
            end
        end else if (mouse_req) begin
            if (can_push) begin
                push        = 1'b1;
                push_dir    = mouse_dir;
                grant_mouse = 1'b1;
            end
        end else begin
            key_ready = can_push;
            if (key_valid && can_push) begin
                push     = 1'b1;
                push_dir = move_dir_t'(key_dir);
            end
        end
        if (rst) key_ready = 1'b0;
    end

    // hold register for a mouse move that lost the tie, plus round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_dir   <= MV_RIGHT;
            last_mouse <= 1'b0;
        end else begin
            if (home) begin
                hold_valid <= 1'b0;
            end else if (hold_load) begin
                hold_valid <= 1'b1;
                hold_dir   <= mouse_dir;
            end else if (hold_clear) begin
                hold_valid <= 1'b0;
            end
            if (push) last_mouse <= grant_mouse;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // next state and pop strobe
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (home) begin
            state_next = ST_HOME;
        end else begin
            case (state)
                ST_IDLE:  if (!empty) state_next = ST_ARMED;
                ST_ARMED: if (frame_start) state_next = ST_APPLY;
                ST_APPLY: begin
                    pop        = 1'b1;
                    state_next = ((count > CW'(1)) || push) ? ST_ARMED : ST_IDLE;
                end
                ST_HOME:  if (frame_start) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // new position from the queue head, clamped or wrapped at the screen edge
    always_comb begin
        x_sum  = {1'b0, xpos_square} + 13'(STEP);
        y_sum  = {1'b0, ypos_square} + 13'(STEP);
        x_next = xpos_square;
        y_next = ypos_square;
        case (move_dir_t'(head))
            MV_RIGHT: x_next = (x_sum > 13'(X_MAX)) ? (WRAP_EN ? 12'd0 : 12'(X_MAX)) : x_sum[11:0];
            MV_LEFT:  x_next = (xpos_square < 12'(STEP)) ? (WRAP_EN ? 12'(X_MAX) : 12'd0)
                                                         : xpos_square - 12'(STEP);
            MV_UP:    y_next = (ypos_square < 12'(STEP)) ? (WRAP_EN ? 12'(Y_MAX) : 12'd0)
                                                         : ypos_square - 12'(STEP);
            MV_DOWN:  y_next = (y_sum > 13'(Y_MAX)) ? (WRAP_EN ? 12'd0 : 12'(Y_MAX)) : y_sum[11:0];
            default: ;
        endcase
    end

    // position registers: update only in APPLY or on the homing frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_square <= 12'(X_INIT);
            ypos_square <= 12'(Y_INIT);
        end else if (!home && state == ST_HOME && frame_start) begin
            xpos_square <= 12'(X_INIT);
            ypos_square <= 12'(Y_INIT);
        end else if (!home && state == ST_APPLY) begin
            xpos_square <= x_next;
            ypos_square <= y_next;
        end
    end

endmodule
